uart_tx_fsm: RTL and testbench

UART transmit framing stage that serialises one parallel data word per frame onto the TX line. Frame order is start bit, data LSB first, optional parity bit, stop bit. It consumes `par_bit` from the parity calculator, which sits alongside it on the same `P_DATA`/`Data_Valid` inputs. It drives `busy` back to the parity calculator so parity is captured only when a frame is accepted. `clk` is the baud-rate clock: one bit per clock cycle.

---
 rtl/uart_tx_fsm.sv | 109 ++++++++++
 tb/tb_uart_tx_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// UART transmit framing FSM: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit. One bit per baud clock; TX_OUT and busy are registered.
module uart_tx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  par_bit,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic                  par_en_q, par_en_n;
   logic                  tx_n, busy_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shift    <= '0;
         par_en_q <= 1'b0;
         TX_OUT   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         shift    <= shift_n;
         par_en_q <= par_en_n;
         TX_OUT   <= tx_n;
         busy     <= busy_n;
      end
   end

   // Outputs are computed one cycle ahead so the line is glitch-free from a flop.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      shift_n  = shift;
      par_en_n = par_en_q;
      tx_n     = TX_OUT;
      busy_n   = busy;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (Data_Valid) begin
               state_n  = START;
               shift_n  = P_DATA;
               par_en_n = PAR_EN;
               cnt_n    = '0;
               tx_n     = 1'b0;
               busy_n   = 1'b1;
            end
         end
         START: begin
            state_n = DATA;
            tx_n    = shift[0];
            shift_n = shift >> 1;
         end
         DATA: begin
            if (cnt == LAST) begin
               if (par_en_q) begin
                  state_n = PARITY;
                  tx_n    = par_bit;
               end else begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end
            end else begin
               tx_n    = shift[0];
               shift_n = shift >> 1;
               cnt_n   = cnt + CW'(1);
            end
         end
         PARITY: begin
            state_n = STOP;
            tx_n    = 1'b1;
         end
         STOP: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: line sequences are hand-written per frame,
// cycle 0 (start bit) in the LSB of each expected-sequence literal.
module tb_uart_tx_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       par_bit;
   logic       TX_OUT;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_fsm #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .par_bit    (par_bit),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Outputs sampled 1 time unit after the rising edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   // Walks a frame whose start bit is already on the line, then checks idle.
   // pulse_at >= 0 pulses Data_Valid with 0xFF during that cycle of the frame.
   task automatic frame(input string tag, input logic [15:0] seq, input int n,
                        input int pulse_at);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s tx[%0d]", tag, i), TX_OUT, seq[i]);
         chk($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
         if (i == pulse_at) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
         end
         step();
         if (i == pulse_at) Data_Valid = 1'b0;
      end
      chk({tag, " idle tx"}, TX_OUT, 1'b1);
      chk({tag, " idle busy"}, busy, 1'b0);
   endtask

   initial begin
      // Reset held 2 cycles with a pending request; then parity-off 0x3C frame
      rst        = 1'b1;
      Data_Valid = 1'b1;
      P_DATA     = 8'h3C;
      PAR_EN     = 1'b0;
      par_bit    = 1'b0;
      step();
      chk("rst0 tx", TX_OUT, 1'b1);
      chk("rst0 busy", busy, 1'b0);
      step();
      chk("rst1 tx", TX_OUT, 1'b1);
      chk("rst1 busy", busy, 1'b0);
      rst = 1'b0;
      step();
      Data_Valid = 1'b0;
      P_DATA     = 8'h00;
      frame("p_off_3C", 16'(10'b1001111000), 10, -1);

      // Parity on, 0xA5, even parity bit 0, single-cycle request
      step();
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b1;
      par_bit    = 1'b0;
      Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      frame("p_on_A5", 16'(11'b10101001010), 11, -1);

      // Request during DATA is ignored; no second frame afterwards
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b1;
      Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      frame("ignore_A5", 16'(11'b10101001010), 11, 4);
      step();
      chk("ignore post tx", TX_OUT, 1'b1);
      chk("ignore post busy", busy, 1'b0);

      // Reset during data bit 4, then a fresh 0x5A frame with parity
      P_DATA     = 8'hA5;
      PAR_EN     = 1'b1;
      Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("mid bit4 tx", TX_OUT, 1'b0);
      rst = 1'b1;
      step();
      chk("mid rst tx", TX_OUT, 1'b1);
      chk("mid rst busy", busy, 1'b0);
      rst = 1'b0;
      step();
      chk("mid idle tx", TX_OUT, 1'b1);
      chk("mid idle busy", busy, 1'b0);
      P_DATA     = 8'h5A;
      PAR_EN     = 1'b1;
      par_bit    = 1'b0;
      Data_Valid = 1'b1;
      step();
      Data_Valid = 1'b0;
      frame("fresh_5A", 16'(11'b10010110100), 11, -1);

      // Back-to-back with Data_Valid held: 0x01 then 0x80, one idle cycle between
      P_DATA     = 8'h01;
      PAR_EN     = 1'b1;
      par_bit    = 1'b1;
      Data_Valid = 1'b1;
      step();
      P_DATA = 8'h80;
      frame("b2b_01", 16'(11'b11000000010), 11, -1);
      step();
      frame("b2b_80", 16'(11'b11100000000), 11, -1);
      Data_Valid = 1'b0;
      step();
      chk("b2b end tx", TX_OUT, 1'b1);
      chk("b2b end busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
